// File: rtl/wash_pkg.sv
// Shared types and constants for the wash heater controller.
package wash_pkg;

  localparam int unsigned TEMP_W = 7;

  localparam logic [2:0] TEM_HIGH = 3'd1;
  localparam logic [2:0] TEM_MED  = 3'd2;
  localparam logic [2:0] TEM_LOW  = 3'd4;

  typedef enum logic [2:0] {IDLE, HEAT, HOLD, DONE, ERR} heat_state_e;

endpackage

// File: rtl/tick_gen.sv
// Free-running strobe generator: one-cycle tick every TICK_DIV clocks.
module tick_gen #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wash_heater_ctrl.sv
// Heating-cycle controller with tick-based water temperature model.
// Optional heat timeout / ERR state enabled by HEATER_TIMEOUT_EN.
module wash_heater_ctrl
  import wash_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned T_AMBIENT  = 20,
  parameter int unsigned T_HIGH     = 60,
  parameter int unsigned T_MED      = 40,
  parameter int unsigned T_LOW      = 30,
  parameter int unsigned HOLD_TICKS = 5
`ifdef HEATER_TIMEOUT_EN
  ,
  parameter int unsigned MAX_HEAT_TICKS = 64
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [2:0]        tem_sel,
  input  logic              start,
  input  logic              abort,
  output logic              heater_on,
  output logic [TEMP_W-1:0] cur_temp,
  output logic [TEMP_W-1:0] target_temp,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [TEMP_W-1:0] TAmb  = TEMP_W'(T_AMBIENT);
  localparam logic [TEMP_W-1:0] TMax  = TEMP_W'(99);
  localparam int unsigned       HoldW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  heat_state_e       state_q;
  logic              heater_on_q, done_q;
  logic [TEMP_W-1:0] cur_temp_q, cur_temp_d, target_q, target_sel;
  logic [HoldW-1:0]  hold_cnt_q;
  logic              tick;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  always_comb begin
    case (tem_sel)
      TEM_HIGH: target_sel = TEMP_W'(T_HIGH);
      TEM_LOW:  target_sel = TEMP_W'(T_LOW);
      default:  target_sel = TEMP_W'(T_MED);
    endcase
  end

  // Water model runs in every state, including after abort.
  always_comb begin
    cur_temp_d = cur_temp_q;
    if (tick) begin
      if (heater_on_q) begin
        if (cur_temp_q < TMax) cur_temp_d = cur_temp_q + TEMP_W'(1);
      end else if (cur_temp_q > TAmb) begin
        cur_temp_d = cur_temp_q - TEMP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cur_temp_q <= TAmb;
    else       cur_temp_q <= cur_temp_d;
  end

`ifdef HEATER_TIMEOUT_EN
  localparam int unsigned HeatW = (MAX_HEAT_TICKS > 1) ? $clog2(MAX_HEAT_TICKS) : 1;
  logic [HeatW-1:0] heat_cnt_q;
  logic             err_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      heater_on_q <= 1'b0;
      target_q    <= TEMP_W'(T_MED);
      done_q      <= 1'b0;
      hold_cnt_q  <= '0;
`ifdef HEATER_TIMEOUT_EN
      heat_cnt_q  <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q     <= IDLE;
        heater_on_q <= 1'b0;
`ifdef HEATER_TIMEOUT_EN
        err_q       <= 1'b0;
`endif
      end else begin
        unique case (state_q)
          IDLE: begin
            heater_on_q <= 1'b0;
            if (start && en) begin
              target_q    <= target_sel;
              state_q     <= HEAT;
              heater_on_q <= 1'b1;
`ifdef HEATER_TIMEOUT_EN
              heat_cnt_q  <= '0;
`endif
            end
          end
          HEAT: begin
            heater_on_q <= 1'b1;
            if (cur_temp_q >= target_q) begin
              state_q     <= HOLD;
              hold_cnt_q  <= '0;
              heater_on_q <= 1'b0;
            end
`ifdef HEATER_TIMEOUT_EN
            else if (tick) begin
              if (heat_cnt_q == HeatW'(MAX_HEAT_TICKS - 1)) begin
                state_q     <= ERR;
                err_q       <= 1'b1;
                heater_on_q <= 1'b0;
              end else begin
                heat_cnt_q <= heat_cnt_q + HeatW'(1);
              end
            end
`endif
          end
          HOLD: begin
            // Bang-bang hold around the target.
            heater_on_q <= (cur_temp_q < target_q);
            if (tick) begin
              if (hold_cnt_q == HoldW'(HOLD_TICKS - 1)) begin
                state_q     <= DONE;
                done_q      <= 1'b1;
                heater_on_q <= 1'b0;
              end else begin
                hold_cnt_q <= hold_cnt_q + HoldW'(1);
              end
            end
          end
          DONE: begin
            heater_on_q <= 1'b0;
            state_q     <= IDLE;
          end
          ERR: begin
            heater_on_q <= 1'b0;
`ifndef HEATER_TIMEOUT_EN
            state_q     <= IDLE;
`endif
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign heater_on   = heater_on_q;
  assign cur_temp    = cur_temp_q;
  assign target_temp = target_q;
  assign busy        = (state_q == HEAT) || (state_q == HOLD);
  assign done        = done_q;
`ifdef HEATER_TIMEOUT_EN
  assign err         = err_q;
`else
  assign err         = 1'b0;
`endif

endmodule
